ex_mem_pipe: RTL and testbench
==============================

EX_MEM_PIPE -- requirements
Module: ex_mem_pipe

Interface
REQ-001 SHALL have ports `clk` (in, 1, the single clock) and `rst` (in, 1); reset is synchronous and active-high.
REQ-002 SHALL have port `valid_in` (in, 1): the execute stage holds a real instruction.
REQ-003 SHALL have port `stall_in` (in, 1): memory stage not ready; hold all state.
REQ-004 SHALL have port `flush_in` (in, 1): kill the held instruction and load a bubble.
REQ-005 SHALL have input ports `aluOutput_in` (16), `storeData_in` (16), `updatedPC_in` (16) and `next_PC_normal_in` (16), all from execute.
REQ-006 SHALL have input ports `writeRegister_in` (3), `regWrite_in` (1), `memRead_in` (1), `memWrite_in` (1), `memToReg_in` (1), `reg7_En_in` (1), `branchingPCEnable_in` (1) and `halt_in` (1).
REQ-007 SHALL have registered output ports `aluOutput_out`, `storeData_out`, `linkPC_out` (16 each), `writeRegister_out` (3), and `regWrite_out`, `memRead_out`, `memWrite_out`, `memToReg_out`, `reg7_En_out`, `valid_out` (1 each).
REQ-008 SHALL have output ports `redirect_out` (1) and `redirectPC_out` (16): the fetch redirect for a taken branch or jump.
REQ-009 SHALL have output ports `fwdValid_out` (1), `fwdReg_out` (3) and `fwdData_out` (16): the EX-to-EX forwarding source.
REQ-010 SHALL have output ports `halted_out` (1, sticky halt) and `err_out` (1, sticky illegal-control error).

Function
REQ-011 Update priority SHALL be: rst > flush_in > stall_in > normal load.
REQ-012 On a normal load (no stall, no flush) all data inputs SHALL be captured in 1 cycle; `linkPC_out` SHALL take `next_PC_normal_in` and `redirectPC_out` SHALL take `updatedPC_in`.
REQ-013 A load with `valid_in`=0 SHALL be a bubble:
- `valid_out`=0;
- `regWrite`, `memRead`, `memWrite`, `reg7_En` and the redirect state all 0;
- data fields don't-care.
REQ-014 Flush SHALL load a bubble regardless of `stall_in` and `valid_in`.
REQ-015 Stall SHALL hold every register, including data, control, valid and the forwarding outputs.
REQ-016 `redirect_out` SHALL be 1 only in the first cycle a valid instruction with `branchingPCEnable` sits in the register.
- An internal `redirDone` flag SHALL be set in that cycle.
- Later stalled cycles of the same instruction SHALL output 0.
- `redirDone` SHALL clear on the next load or flush.
REQ-017 `fwdValid_out` SHALL equal `valid_out` & `regWrite_out` & !`memRead_out` (no forwarding of loads).
- `fwdReg_out` SHALL equal `writeRegister_out`.
- `fwdData_out` SHALL equal `linkPC_out` when `reg7_En_out` is 1, else `aluOutput_out`.
REQ-018 `halted_out` SHALL set on the cycle after loading a valid instruction with `halt_in`=1.
- Once set, every later load SHALL be a bubble.
- It SHALL clear only on rst; flush does not clear it.
REQ-019 The halt instruction itself SHALL load normally, with valid and its control bits as supplied.
REQ-020 A valid load with `memRead_in`=`memWrite_in`=1 SHALL set sticky `err_out`, and SHALL load as a bubble.
REQ-021 `valid_in`=1 together with flush in the same cycle SHALL leave a bubble; the incoming instruction is discarded and execute re-issues it.
REQ-022 State machine on `redirDone`: IDLE -> PULSED on a valid redirect instruction; PULSED -> IDLE on load or flush; PULSED holds while stalled.
REQ-023 The block SHALL contain no combinational path from inputs to outputs; every output is a function of registers only.

Reset
REQ-024 rst SHALL clear to 0, in the cycle after the rst edge: every output, `redirDone`, `halted_out` and `err_out`.
REQ-025 rst mid-stall or mid-redirect SHALL discard the held instruction; no `redirect_out` pulse SHALL appear after rst.

Verification
REQ-026 Normal load: `valid_in`=1, `aluOutput_in`=16'h1234, `writeRegister_in`=3, `regWrite_in`=1 -> next cycle `aluOutput_out`=16'h1234, `fwdValid_out`=1, `fwdReg_out`=3, `fwdData_out`=16'h1234.
REQ-027 Redirect under stall: load a valid instruction with `branchingPCEnable_in`=1 and `updatedPC_in`=16'h0040, then stall 3 cycles -> `redirect_out`=1 for exactly 1 cycle; `redirectPC_out`=16'h0040 held all 4 cycles.
REQ-028 Flush vs stall: `stall_in`=1 and `flush_in`=1 together -> next cycle `valid_out`=0, `regWrite_out`=0, `memWrite_out`=0.
REQ-029 JAL forwarding: valid load with `reg7_En_in`=1, `next_PC_normal_in`=16'h0102, `aluOutput_in`=16'hBEEF -> `fwdData_out`=16'h0102, `linkPC_out`=16'h0102.
REQ-030 Halt: valid `halt_in`=1, then 2 further valid loads -> `halted_out`=1 from cycle+1; the next 2 loads give `valid_out`=0; rst clears `halted_out` to 0.
REQ-031 Illegal control: valid load with `memRead_in`=`memWrite_in`=1 -> `err_out`=1 sticky and `valid_out`=0; a following rst gives `err_out`=0.

Source files
------------

// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register: captures execute results, generates a one-shot fetch
// redirect, exposes an EX-to-EX forwarding source, and tracks sticky halt/error.
module ex_mem_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic        stall_in,
  input  logic        flush_in,
  input  logic [15:0] aluOutput_in,
  input  logic [15:0] storeData_in,
  input  logic [15:0] updatedPC_in,
  input  logic [15:0] next_PC_normal_in,
  input  logic [2:0]  writeRegister_in,
  input  logic        regWrite_in,
  input  logic        memRead_in,
  input  logic        memWrite_in,
  input  logic        memToReg_in,
  input  logic        reg7_En_in,
  input  logic        branchingPCEnable_in,
  input  logic        halt_in,
  output logic [15:0] aluOutput_out,
  output logic [15:0] storeData_out,
  output logic [15:0] linkPC_out,
  output logic [2:0]  writeRegister_out,
  output logic        regWrite_out,
  output logic        memRead_out,
  output logic        memWrite_out,
  output logic        memToReg_out,
  output logic        reg7_En_out,
  output logic        valid_out,
  output logic        redirect_out,
  output logic [15:0] redirectPC_out,
  output logic        fwdValid_out,
  output logic [2:0]  fwdReg_out,
  output logic [15:0] fwdData_out,
  output logic        halted_out,
  output logic        err_out
);

  // state  | meaning
  // IDLE   | held instruction has not yet issued its redirect pulse (redirDone=0)
  // PULSED | redirect already issued; held under stall until next load/flush
  typedef enum logic {IDLE, PULSED} redir_state_e;

  redir_state_e redir_q, redir_d;
  logic [15:0] alu_q, alu_d, store_q, store_d, link_q, link_d, rpc_q, rpc_d;
  logic [2:0]  wreg_q, wreg_d;
  logic        regwrite_q, regwrite_d, memread_q, memread_d, memwrite_q, memwrite_d;
  logic        memtoreg_q, memtoreg_d, reg7_q, reg7_d, valid_q, valid_d;
  logic        branch_q, branch_d, halted_q, halted_d, err_q, err_d;
  logic        load, illegal, eff_valid, redirect;

  always_comb begin
    load      = !flush_in && !stall_in;
    illegal   = valid_in && !halted_q && memRead_in && memWrite_in;
    eff_valid = valid_in && !halted_q && !illegal;
    redirect  = valid_q && branch_q && (redir_q == IDLE);
  end

  always_comb begin
    alu_d      = alu_q;
    store_d    = store_q;
    link_d     = link_q;
    rpc_d      = rpc_q;
    wreg_d     = wreg_q;
    regwrite_d = regwrite_q;
    memread_d  = memread_q;
    memwrite_d = memwrite_q;
    memtoreg_d = memtoreg_q;
    reg7_d     = reg7_q;
    valid_d    = valid_q;
    branch_d   = branch_q;
    halted_d   = halted_q;
    err_d      = err_q;
    if (flush_in) begin
      valid_d    = 1'b0;
      regwrite_d = 1'b0;
      memread_d  = 1'b0;
      memwrite_d = 1'b0;
      memtoreg_d = 1'b0;
      reg7_d     = 1'b0;
      branch_d   = 1'b0;
      rpc_d      = 16'h0000;
    end else if (load) begin
      // Data fields are captured even for bubbles; only control is squashed.
      alu_d      = aluOutput_in;
      store_d    = storeData_in;
      link_d     = next_PC_normal_in;
      wreg_d     = writeRegister_in;
      valid_d    = eff_valid;
      regwrite_d = eff_valid && regWrite_in;
      memread_d  = eff_valid && memRead_in;
      memwrite_d = eff_valid && memWrite_in;
      memtoreg_d = eff_valid && memToReg_in;
      reg7_d     = eff_valid && reg7_En_in;
      branch_d   = eff_valid && branchingPCEnable_in;
      rpc_d      = eff_valid ? updatedPC_in : 16'h0000;
      halted_d   = halted_q || (eff_valid && halt_in);
      err_d      = err_q || illegal;
    end
  end

  always_comb begin
    redir_d = redir_q;
    if (flush_in || !stall_in) redir_d = IDLE;
    else if (redirect)         redir_d = PULSED;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      redir_q    <= IDLE;
      alu_q      <= '0;
      store_q    <= '0;
      link_q     <= '0;
      rpc_q      <= '0;
      wreg_q     <= '0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      reg7_q     <= 1'b0;
      valid_q    <= 1'b0;
      branch_q   <= 1'b0;
      halted_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      redir_q    <= redir_d;
      alu_q      <= alu_d;
      store_q    <= store_d;
      link_q     <= link_d;
      rpc_q      <= rpc_d;
      wreg_q     <= wreg_d;
      regwrite_q <= regwrite_d;
      memread_q  <= memread_d;
      memwrite_q <= memwrite_d;
      memtoreg_q <= memtoreg_d;
      reg7_q     <= reg7_d;
      valid_q    <= valid_d;
      branch_q   <= branch_d;
      halted_q   <= halted_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    aluOutput_out     = alu_q;
    storeData_out     = store_q;
    linkPC_out        = link_q;
    writeRegister_out = wreg_q;
    regWrite_out      = regwrite_q;
    memRead_out       = memread_q;
    memWrite_out      = memwrite_q;
    memToReg_out      = memtoreg_q;
    reg7_En_out       = reg7_q;
    valid_out         = valid_q;
    redirect_out      = redirect;
    redirectPC_out    = rpc_q;
    fwdValid_out      = valid_q && regwrite_q && !memread_q;
    fwdReg_out        = wreg_q;
    fwdData_out       = reg7_q ? link_q : alu_q;
    halted_out        = halted_q;
    err_out           = err_q;
  end

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Bench for ex_mem_pipe: directed scenarios plus randomized traffic compared
// against an instruction-level reference model.
module tb_ex_mem_pipe;
  logic        clk = 1'b0;
  logic        rst, valid_in, stall_in, flush_in;
  logic [15:0] aluOutput_in, storeData_in, updatedPC_in, next_PC_normal_in;
  logic [2:0]  writeRegister_in;
  logic        regWrite_in, memRead_in, memWrite_in, memToReg_in, reg7_En_in;
  logic        branchingPCEnable_in, halt_in;
  logic [15:0] aluOutput_out, storeData_out, linkPC_out, redirectPC_out, fwdData_out;
  logic [2:0]  writeRegister_out, fwdReg_out;
  logic        regWrite_out, memRead_out, memWrite_out, memToReg_out, reg7_En_out;
  logic        valid_out, redirect_out, fwdValid_out, halted_out, err_out;

  int checks = 0;
  int failures = 0;

  ex_mem_pipe dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .stall_in(stall_in), .flush_in(flush_in),
    .aluOutput_in(aluOutput_in), .storeData_in(storeData_in), .updatedPC_in(updatedPC_in),
    .next_PC_normal_in(next_PC_normal_in), .writeRegister_in(writeRegister_in),
    .regWrite_in(regWrite_in), .memRead_in(memRead_in), .memWrite_in(memWrite_in),
    .memToReg_in(memToReg_in), .reg7_En_in(reg7_En_in),
    .branchingPCEnable_in(branchingPCEnable_in), .halt_in(halt_in),
    .aluOutput_out(aluOutput_out), .storeData_out(storeData_out), .linkPC_out(linkPC_out),
    .writeRegister_out(writeRegister_out), .regWrite_out(regWrite_out),
    .memRead_out(memRead_out), .memWrite_out(memWrite_out), .memToReg_out(memToReg_out),
    .reg7_En_out(reg7_En_out), .valid_out(valid_out), .redirect_out(redirect_out),
    .redirectPC_out(redirectPC_out), .fwdValid_out(fwdValid_out), .fwdReg_out(fwdReg_out),
    .fwdData_out(fwdData_out), .halted_out(halted_out), .err_out(err_out)
  );

  always #5 clk = ~clk;

  // Reference: the instruction currently held, and how many cycles it has been held.
  typedef struct {
    bit        valid, rw, mr, mw, m2r, r7, br;
    bit [15:0] alu, st, link, rpc;
    bit [2:0]  wreg;
  } instr_t;
  instr_t m_held;
  int     m_age;
  bit     m_halted, m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    rst = 0; valid_in = 0; stall_in = 0; flush_in = 0;
    aluOutput_in = 0; storeData_in = 0; updatedPC_in = 0; next_PC_normal_in = 0;
    writeRegister_in = 0; regWrite_in = 0; memRead_in = 0; memWrite_in = 0;
    memToReg_in = 0; reg7_En_in = 0; branchingPCEnable_in = 0; halt_in = 0;
  endtask

  task automatic model_update();
    instr_t n;
    bit     accepted;
    if (rst) begin
      m_held = '{default: 0};
      m_age = 0; m_halted = 0; m_err = 0;
    end else if (flush_in) begin
      m_held = '{default: 0};
      m_age = 0;
    end else if (stall_in) begin
      m_age++;
    end else begin
      n = '{default: 0};
      accepted = valid_in && !m_halted && !(memRead_in && memWrite_in);
      if (valid_in && !m_halted && memRead_in && memWrite_in) m_err = 1;
      if (accepted) begin
        n.valid = 1; n.rw = regWrite_in; n.mr = memRead_in; n.mw = memWrite_in;
        n.m2r = memToReg_in; n.r7 = reg7_En_in; n.br = branchingPCEnable_in;
        n.alu = aluOutput_in; n.st = storeData_in; n.link = next_PC_normal_in;
        n.rpc = updatedPC_in; n.wreg = writeRegister_in;
        if (halt_in) m_halted = 1;
      end
      m_held = n;
      m_age = 0;
    end
  endtask

  task automatic check_all();
    chk("valid", valid_out, m_held.valid);
    chk("regWrite", regWrite_out, m_held.rw);
    chk("memRead", memRead_out, m_held.mr);
    chk("memWrite", memWrite_out, m_held.mw);
    chk("reg7_En", reg7_En_out, m_held.r7);
    chk("redirect", redirect_out, m_held.valid && m_held.br && m_age == 0);
    chk("redirectPC", redirectPC_out, m_held.rpc);
    chk("fwdValid", fwdValid_out, m_held.valid && m_held.rw && !m_held.mr);
    chk("halted", halted_out, m_halted);
    chk("err", err_out, m_err);
    if (m_held.valid) begin
      chk("aluOutput", aluOutput_out, m_held.alu);
      chk("storeData", storeData_out, m_held.st);
      chk("linkPC", linkPC_out, m_held.link);
      chk("writeRegister", writeRegister_out, m_held.wreg);
      chk("memToReg", memToReg_out, m_held.m2r);
      chk("fwdReg", fwdReg_out, m_held.wreg);
      chk("fwdData", fwdData_out, m_held.r7 ? m_held.link : m_held.alu);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  initial begin
    clear_inputs();
    m_held = '{default: 0}; m_age = 0; m_halted = 0; m_err = 0;
    rst = 1;
    step(); step();
    chk("reset_outputs", {aluOutput_out, linkPC_out}, 32'h0);
    chk("reset_misc", {storeData_out, redirectPC_out}, 32'h0);
    chk("reset_fwd", {fwdData_out, fwdReg_out, fwdValid_out, redirect_out,
                      halted_out, err_out, writeRegister_out}, 32'h0);
    rst = 0;

    // Normal load with forwarding
    valid_in = 1; aluOutput_in = 16'h1234; writeRegister_in = 3; regWrite_in = 1;
    step();
    chk("n_alu", aluOutput_out, 16'h1234);
    chk("n_fwdValid", fwdValid_out, 1);
    chk("n_fwdReg", fwdReg_out, 3);
    chk("n_fwdData", fwdData_out, 16'h1234);

    // Redirect held under a 3-cycle stall
    clear_inputs();
    valid_in = 1; branchingPCEnable_in = 1; updatedPC_in = 16'h0040;
    step();
    chk("r_pulse0", redirect_out, 1);
    chk("r_pc0", redirectPC_out, 16'h0040);
    clear_inputs(); stall_in = 1;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("r_pulse_stall", redirect_out, 0);
      chk("r_pc_stall", redirectPC_out, 16'h0040);
    end

    // Flush beats stall
    clear_inputs();
    valid_in = 1; regWrite_in = 1; memWrite_in = 1; stall_in = 1; flush_in = 1;
    step();
    chk("f_valid", valid_out, 0);
    chk("f_regWrite", regWrite_out, 0);
    chk("f_memWrite", memWrite_out, 0);

    // JAL forwarding picks the link PC
    clear_inputs();
    valid_in = 1; reg7_En_in = 1; regWrite_in = 1; writeRegister_in = 7;
    next_PC_normal_in = 16'h0102; aluOutput_in = 16'hBEEF;
    step();
    chk("j_fwdData", fwdData_out, 16'h0102);
    chk("j_linkPC", linkPC_out, 16'h0102);

    // Halt: itself loads, later loads become bubbles, flush keeps it, rst clears it
    clear_inputs();
    valid_in = 1; halt_in = 1; regWrite_in = 1;
    step();
    chk("h_set", halted_out, 1);
    chk("h_self_valid", valid_out, 1);
    halt_in = 0;
    step(); chk("h_bubble1", valid_out, 0);
    step(); chk("h_bubble2", valid_out, 0);
    flush_in = 1; step(); flush_in = 0;
    chk("h_flush_keeps", halted_out, 1);
    rst = 1; step(); rst = 0;
    chk("h_rst_clears", halted_out, 0);

    // Illegal read+write control
    clear_inputs();
    valid_in = 1; memRead_in = 1; memWrite_in = 1;
    step();
    chk("e_set", err_out, 1);
    chk("e_bubble", valid_out, 0);
    memRead_in = 0; memWrite_in = 0;
    step();
    chk("e_sticky", err_out, 1);
    rst = 1; step(); rst = 0;
    chk("e_rst_clears", err_out, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst                  = ($urandom_range(99) < 2);
      flush_in             = ($urandom_range(99) < 8);
      stall_in             = ($urandom_range(99) < 30);
      valid_in             = ($urandom_range(99) < 75);
      halt_in              = ($urandom_range(99) < 2);
      memRead_in           = ($urandom_range(99) < 30);
      memWrite_in          = ($urandom_range(99) < 25);
      regWrite_in          = $urandom_range(1);
      memToReg_in          = $urandom_range(1);
      reg7_En_in           = ($urandom_range(99) < 25);
      branchingPCEnable_in = ($urandom_range(99) < 35);
      writeRegister_in     = 3'($urandom_range(7));
      aluOutput_in         = 16'($urandom);
      storeData_in         = 16'($urandom);
      updatedPC_in         = 16'($urandom);
      next_PC_normal_in    = 16'($urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
